// File: rtl/vid_pattern_gen.sv
// Video timing and test-pattern generator for a parallel-RGB transmitter input.
// Geometry, sync polarity and colour depth are parameters; pattern and enable apply only at frame boundaries.
module vid_pattern_gen #(
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int BPC      = 12,
    parameter int CNTR_W   = 12
) (
    input  logic             vid_clk,
    input  logic             vid_reset_n,
    input  logic             enable,
    input  logic [1:0]       pattern_sel,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [BPC-1:0]   r,
    output logic [BPC-1:0]   g,
    output logic [BPC-1:0]   b,
    output logic             frame_start
);

    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE;

    localparam logic [CNTR_W-1:0] H_FRONT_C = CNTR_W'(H_FRONT);
    localparam logic [CNTR_W-1:0] HS_END_C  = CNTR_W'(H_FRONT + H_SYNC);
    localparam logic [CNTR_W-1:0] H_BLANK_C = CNTR_W'(H_BLANK);
    localparam logic [CNTR_W-1:0] H_LAST_C  = CNTR_W'(H_TOTAL - 1);
    localparam logic [CNTR_W-1:0] V_FRONT_C = CNTR_W'(V_FRONT);
    localparam logic [CNTR_W-1:0] VS_END_C  = CNTR_W'(V_FRONT + V_SYNC);
    localparam logic [CNTR_W-1:0] V_BLANK_C = CNTR_W'(V_BLANK);
    localparam logic [CNTR_W-1:0] V_LAST_C  = CNTR_W'(V_TOTAL - 1);
    localparam logic [CNTR_W-1:0] OFF_LAST_C = CNTR_W'(V_ACTIVE - 1);
    localparam logic [CNTR_W-1:0] BAR_LAST_C = CNTR_W'(H_ACTIVE / 8 - 1);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);
    localparam logic [BPC-1:0] ONES = {BPC{1'b1}};

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNTR_W-1:0]  col_q, col_d;
    logic [CNTR_W-1:0]  line_q, line_d;
    logic [CNTR_W-1:0]  off_q, off_d;
    logic [1:0]         pat_q, pat_d;
    logic [2:0]         bar_q, bar_d;
    logic [CNTR_W-1:0]  bar_px_q, bar_px_d;

    logic               de_d, hsync_d, vsync_d, frame_start_d;
    logic [BPC-1:0]     r_d, g_d, b_d;
    logic [CNTR_W-1:0]  x, y;
    logic [2:0]         k;
    logic               run;

    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            line_q      <= '0;
            off_q       <= '0;
            pat_q       <= '0;
            bar_q       <= '0;
            bar_px_q    <= '0;
            de          <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            line_q      <= line_d;
            off_q       <= off_d;
            pat_q       <= pat_d;
            bar_q       <= bar_d;
            bar_px_q    <= bar_px_d;
            de          <= de_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            r           <= r_d;
            g           <= g_d;
            b           <= b_d;
            frame_start <= frame_start_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        line_d   = line_q;
        off_d    = off_q;
        pat_d    = pat_q;
        bar_d    = bar_q;
        bar_px_d = bar_px_q;
        case (state_q)
            IDLE: begin
                col_d  = '0;
                line_d = '0;
                off_d  = '0;
                if (enable) begin
                    state_d = RUN;
                    pat_d   = pattern_sel;
                end
            end
            RUN: begin
                if (col_q == H_LAST_C) begin
                    col_d = '0;
                    if (line_q == V_LAST_C) begin
                        line_d = '0;
                        // Frame boundary: the only point where run requests and pattern changes land.
                        if (enable) begin
                            pat_d = pattern_sel;
                            off_d = (off_q == OFF_LAST_C) ? '0 : off_q + 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        line_d = line_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        endcase

        // Bar index tracks col so it lines up with x=0 without a divider.
        if (col_d == H_BLANK_C) begin
            bar_d    = '0;
            bar_px_d = '0;
        end else if (bar_px_q == BAR_LAST_C) begin
            bar_d    = bar_q + 1'b1;
            bar_px_d = '0;
        end else begin
            bar_px_d = bar_px_q + 1'b1;
        end
    end

    always_comb begin
        run  = (state_q == RUN);
        x    = col_q - H_BLANK_C;
        y    = line_q - V_BLANK_C;
        k    = 3'd7 - bar_q;
        de_d = run && (col_q >= H_BLANK_C) && (line_q >= V_BLANK_C);
        hsync_d = (run && (col_q >= H_FRONT_C) && (col_q < HS_END_C)) ? HS_ON : ~HS_ON;
        vsync_d = (run && (line_q >= V_FRONT_C) && (line_q < VS_END_C)) ? VS_ON : ~VS_ON;
        frame_start_d = run && (col_q == '0) && (line_q == '0);
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (de_d) begin
            case (pat_q)
                2'd0: begin
                    b_d = BPC'(x) << 3;
                    if (y < off_q) begin
                        r_d = ONES;
                        g_d = BPC'(y) << 3;
                    end else begin
                        r_d = BPC'(y) << 3;
                        g_d = ONES;
                    end
                end
                2'd1: begin
                    r_d = k[2] ? ONES : '0;
                    g_d = k[1] ? ONES : '0;
                    b_d = k[0] ? ONES : '0;
                end
                2'd2: begin
                    r_d = (x[5] ^ y[5]) ? ONES : '0;
                    g_d = r_d;
                    b_d = r_d;
                end
                default: begin
                    r_d = BPC'(x[7:0]) << (BPC - 8);
                    g_d = r_d;
                    b_d = r_d;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Bench for vid_pattern_gen on a reduced geometry: per-cycle model compare plus literal pixel checks.
module tb_vid_pattern_gen;

    localparam int HF = 2, HS = 3, HBK = 2, HA = 64;
    localparam int VF = 1, VS = 2, VBK = 1, VA = 8;
    localparam int HSP = 0, VSP = 1, BPC = 8, CW = 8;
    localparam int HB = HF + HS + HBK;      // 7
    localparam int HT = HB + HA;            // 71
    localparam int VB = VF + VS + VBK;      // 4
    localparam int VT = VB + VA;            // 12
    localparam int FRAME = HT * VT;         // 852
    localparam int ONES = (1 << BPC) - 1;

    logic           vid_clk = 1'b0;
    logic           vid_reset_n = 1'b0;
    logic           enable = 1'b0;
    logic [1:0]     pattern_sel = 2'd0;
    logic           de, hsync, vsync, frame_start;
    logic [BPC-1:0] r, g, b;

    always #5 vid_clk = ~vid_clk;

    vid_pattern_gen #(
        .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HBK), .H_ACTIVE(HA),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VBK), .V_ACTIVE(VA),
        .HS_POL(HSP), .VS_POL(VSP), .BPC(BPC), .CNTR_W(CW)
    ) dut (
        .vid_clk(vid_clk), .vid_reset_n(vid_reset_n), .enable(enable),
        .pattern_sel(pattern_sel), .de(de), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b), .frame_start(frame_start)
    );

    typedef struct packed {
        logic de; logic hs; logic vs; logic fs;
        logic [BPC-1:0] r; logic [BPC-1:0] g; logic [BPC-1:0] b;
    } pix_t;

    // Outputs implied by a flat pixel index within the frame.
    function automatic pix_t model_pix(input bit run, input int pos, input int off, input int pat);
        pix_t p;
        int col, line, x, y, k, c;
        p = '0;
        p.hs = (HSP == 0);
        p.vs = (VSP == 0);
        if (run) begin
            col  = pos % HT;
            line = pos / HT;
            if (col >= HF && col < HF + HS) p.hs = (HSP != 0);
            if (line >= VF && line < VF + VS) p.vs = (VSP != 0);
            p.fs = (pos == 0);
            p.de = (col >= HB) && (line >= VB);
            if (p.de) begin
                x = col - HB;
                y = line - VB;
                case (pat)
                    0: begin
                        p.b = BPC'((x * 8) & ONES);
                        if (y < off) begin
                            p.r = BPC'(ONES);
                            p.g = BPC'((y * 8) & ONES);
                        end else begin
                            p.r = BPC'((y * 8) & ONES);
                            p.g = BPC'(ONES);
                        end
                    end
                    1: begin
                        k = 7 - x / (HA / 8);
                        p.r = ((k & 4) != 0) ? BPC'(ONES) : '0;
                        p.g = ((k & 2) != 0) ? BPC'(ONES) : '0;
                        p.b = ((k & 1) != 0) ? BPC'(ONES) : '0;
                    end
                    2: begin
                        c = (((x / 32) % 2) != ((y / 32) % 2)) ? ONES : 0;
                        p.r = BPC'(c); p.g = BPC'(c); p.b = BPC'(c);
                    end
                    default: begin
                        c = ((x % 256) << (BPC - 8)) & ONES;
                        p.r = BPC'(c); p.g = BPC'(c); p.b = BPC'(c);
                    end
                endcase
            end
        end
        return p;
    endfunction

    bit   m_run = 1'b0;
    int   m_pos = 0, m_off = 0, m_pat = 0;
    pix_t exp_pix;

    always @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            m_run   <= 1'b0;
            m_pos   <= 0;
            m_off   <= 0;
            m_pat   <= 0;
            exp_pix <= model_pix(1'b0, 0, 0, 0);
        end else begin
            exp_pix <= model_pix(m_run, m_pos, m_off, m_pat);
            if (!m_run) begin
                if (enable) begin
                    m_run <= 1'b1;
                    m_pos <= 0;
                    m_off <= 0;
                    m_pat <= int'(pattern_sel);
                end
            end else if (m_pos == FRAME - 1) begin
                m_pos <= 0;
                if (enable) begin
                    m_off <= (m_off + 1) % VA;
                    m_pat <= int'(pattern_sel);
                end else begin
                    m_run <= 1'b0;
                end
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 1'b0;
    int   cur_pos = 0;
    int   wait_n;
    pix_t dut_pix;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(negedge vid_clk);
        cur_pos++;
        if (chk_en) begin
            dut_pix = {de, hsync, vsync, frame_start, r, g, b};
            n_checks++;
            if (dut_pix !== exp_pix) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t got de=%b hs=%b vs=%b fs=%b r=%0h g=%0h b=%0h expected de=%b hs=%b vs=%b fs=%b r=%0h g=%0h b=%0h",
                         $time, dut_pix.de, dut_pix.hs, dut_pix.vs, dut_pix.fs, dut_pix.r, dut_pix.g, dut_pix.b,
                         exp_pix.de, exp_pix.hs, exp_pix.vs, exp_pix.fs, exp_pix.r, exp_pix.g, exp_pix.b);
            end
        end
    endtask

    task automatic goto_pos(input int p);
        while (cur_pos < p) tick();
    endtask

    // Advances to the next frame_start and checks the distance from the previous one.
    task automatic wait_fs(input bit check_period);
        int start;
        start  = cur_pos;
        wait_n = 0;
        do begin
            tick();
            wait_n++;
        end while (frame_start !== 1'b1 && wait_n < 2 * FRAME);
        if (frame_start !== 1'b1) chk("fs_timeout", 32'(frame_start), 32'd1);
        if (check_period) chk("fs_period", 32'(start + wait_n), 32'(FRAME));
        cur_pos = 0;
    endtask

    task automatic chk_rgb(input string name, input int er, input int eg, input int eb);
        chk({name, "_r"}, 32'(r), 32'(er));
        chk({name, "_g"}, 32'(g), 32'(eg));
        chk({name, "_b"}, 32'(b), 32'(eb));
    endtask

    initial begin
        repeat (3) @(posedge vid_clk);
        @(negedge vid_clk);
        vid_reset_n = 1'b1;
        chk_en = 1'b1;
        tick(); tick();
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk_rgb("rst", 0, 0, 0);

        // Colour bars; frame_start two cycles after enable.
        pattern_sel = 2'd1;
        enable = 1'b1;
        tick();
        chk("fs_lat1", 32'(frame_start), 32'd0);
        tick();
        chk("fs_lat2", 32'(frame_start), 32'd1);
        cur_pos = 0;
        goto_pos(1);   chk("hs_col1", 32'(hsync), 32'd1);
        goto_pos(2);   chk("hs_col2", 32'(hsync), 32'd0);
        goto_pos(4);   chk("hs_col4", 32'(hsync), 32'd0);
        goto_pos(5);   chk("hs_col5", 32'(hsync), 32'd1);
        goto_pos(71);  chk("vs_line1", 32'(vsync), 32'd1);
        goto_pos(213); chk("vs_line3", 32'(vsync), 32'd0);
        goto_pos(290); chk("de_before", 32'(de), 32'd0);
        goto_pos(291); chk("de_x0", 32'(de), 32'd1); chk_rgb("bar_x0", 255, 255, 255);
        goto_pos(299); chk_rgb("bar_x8", 255, 255, 0);
        goto_pos(307); chk_rgb("bar_x16", 255, 0, 255);
        goto_pos(354); chk_rgb("bar_x63", 0, 0, 0);
        goto_pos(426);
        pattern_sel = 2'd3;
        goto_pos(512); chk_rgb("bar_midchg", 255, 255, 0);

        // Grey ramp in the next frame; enable glitch must not interrupt it.
        wait_fs(1'b1);
        goto_pos(100); enable = 1'b0;
        goto_pos(200); enable = 1'b1;
        goto_pos(328); chk_rgb("ramp_x37", 37, 37, 37);
        pattern_sel = 2'd2;
        wait_fs(1'b1);
        goto_pos(322); chk_rgb("chk_x31", 0, 0, 0);
        goto_pos(323); chk_rgb("chk_x32", 255, 255, 255);

        // Drop enable mid-frame: frame completes, then idle.
        pattern_sel = 2'd0;
        goto_pos(426); enable = 1'b0;
        goto_pos(FRAME - 1);
        chk("last_de", 32'(de), 32'd1);
        chk("last_r", 32'(r), 32'd255);
        tick();
        chk("idle_de", 32'(de), 32'd0);
        chk("idle_hsync", 32'(hsync), 32'd1);
        chk("idle_fs", 32'(frame_start), 32'd0);
        chk_rgb("idle", 0, 0, 0);
        repeat (30) tick();
        chk("idle_stay_de", 32'(de), 32'd0);

        // Split-scroll from a fresh start: offset 0, then 1, then wraps after VA frames.
        enable = 1'b1;
        tick();
        chk("re_fs1", 32'(frame_start), 32'd0);
        tick();
        chk("re_fs2", 32'(frame_start), 32'd1);
        cur_pos = 0;
        goto_pos(331); chk_rgb("scr_f1_y0", 0, 255, 64);
        wait_fs(1'b1);
        goto_pos(331); chk_rgb("scr_f2_y0", 255, 0, 64);
        goto_pos(402); chk_rgb("scr_f2_y1", 8, 255, 64);
        for (int f = 0; f < VA - 1; f++) wait_fs(1'b1);
        goto_pos(331); chk_rgb("scr_f9_y0", 0, 255, 64);

        // Asynchronous reset in the middle of an active line.
        goto_pos(700);
        #2 vid_reset_n = 1'b0;
        #1;
        chk("arst_de", 32'(de), 32'd0);
        chk("arst_hsync", 32'(hsync), 32'd1);
        chk("arst_vsync", 32'(vsync), 32'd0);
        chk_rgb("arst", 0, 0, 0);
        enable = 1'b0;
        tick(); tick();
        vid_reset_n = 1'b1;
        repeat (20) tick();
        chk("post_rst_de", 32'(de), 32'd0);
        chk("post_rst_fs", 32'(frame_start), 32'd0);
        enable = 1'b1;
        tick(); tick();
        chk("post_rst_start", 32'(frame_start), 32'd1);
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
